// File: rtl/pc_predict_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_predict_if
// Description : Fetch-side bus of the PC prediction unit. It groups the
//               instruction-memory data, the execute-stage redirect and
//               training inputs, and the fetch PC / prediction outputs.
//               The 'slave' modport is the predictor. The 'master' modport
//               is the surrounding pipeline, or the bench.
// Ports       : stall, instruction, redirectValid/redirectPC,
//               updateValid/updatePC/updateTaken  (master -> slave)
//               pc, predTaken                      (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_predict_if;
    logic        stall;
    logic [31:0] instruction;
    logic        redirectValid;
    logic [31:0] redirectPC;
    logic        updateValid;
    logic [31:0] updatePC;
    logic        updateTaken;
    logic [31:0] pc;
    logic        predTaken;

    modport master (
        output stall, instruction, redirectValid, redirectPC,
               updateValid, updatePC, updateTaken,
        input  pc, predTaken
    );

    modport slave (
        input  stall, instruction, redirectValid, redirectPC,
               updateValid, updatePC, updateTaken,
        output pc, predTaken
    );
endinterface
`default_nettype wire

// File: rtl/pc_predict.sv
`default_nettype none
// ============================================================================
// Module      : pc_predict
// Description : Fetch-stage PC unit with dynamic prediction. A table of
//               2-bit saturating counters predicts conditional branches.
//               A circular return-address stack predicts jr $31. The
//               next PC is computed combinationally from the fetched
//               instruction.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - pc_predict_if.slave (fetch/execute signals, pc,
//                        predTaken)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_predict #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 64,
    parameter int          RAS_DEPTH   = 4
) (
    input  wire           clk,
    input  wire           rst_n,
    pc_predict_if.slave   bus
);
    localparam int c_idx_w = $clog2(BHT_ENTRIES);
    localparam int c_ptr_w = $clog2(RAS_DEPTH);

    localparam logic [5:0] c_op_special = 6'h00;
    localparam logic [5:0] c_op_regimm  = 6'h01;
    localparam logic [5:0] c_op_j       = 6'h02;
    localparam logic [5:0] c_op_jal     = 6'h03;
    localparam logic [5:0] c_op_beq     = 6'h04;
    localparam logic [5:0] c_op_bne     = 6'h05;
    localparam logic [5:0] c_op_blez    = 6'h06;
    localparam logic [5:0] c_op_bgtz    = 6'h07;
    localparam logic [5:0] c_fn_jr      = 6'h08;
    localparam logic [c_ptr_w:0] c_ras_full = (c_ptr_w+1)'(RAS_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]        pc_q, pc_d;
    logic [1:0]         bht_q [BHT_ENTRIES];
    logic [31:0]        ras_q [RAS_DEPTH];
    // The top pointer addresses the next free slot. The newest entry is
    // at top-1. Pointer arithmetic wraps because the depth is a power of
    // two.
    logic [c_ptr_w-1:0] ras_top_q, ras_top_d;
    logic [c_ptr_w:0]   ras_cnt_q, ras_cnt_d;

    // ------------------------------------------------------------------
    // Instruction decode and candidate targets
    // ------------------------------------------------------------------
    logic [5:0]         w_op, w_funct;
    logic [4:0]         w_rs;
    logic [31:0]        w_seq, w_br_t, w_j_t, w_pred_pc;
    logic [c_idx_w-1:0] w_rd_idx, w_upd_idx;
    logic               w_push, w_pop, w_commit;
    logic [1:0]         w_upd_cnt;

    assign w_op      = bus.instruction[31:26];
    assign w_funct   = bus.instruction[5:0];
    assign w_rs      = bus.instruction[25:21];
    assign w_seq     = pc_q + 32'd4;
    assign w_br_t    = w_seq + {{14{bus.instruction[15]}}, bus.instruction[15:0], 2'b00};
    assign w_j_t     = {w_seq[31:28], bus.instruction[25:0], 2'b00};
    assign w_rd_idx  = pc_q[c_idx_w+1:2];
    assign w_upd_idx = bus.updatePC[c_idx_w+1:2];

    // Upper bits of updatePC do not select a counter.
    logic w_unused_upd;
    assign w_unused_upd = &{1'b0, bus.updatePC};

    // RAS side effects are speculative. They are committed only on a
    // cycle that really advances along the predicted path.
    assign w_commit = !bus.stall && !bus.redirectValid;

    always_comb begin
        w_pred_pc = w_seq;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        case (w_op)
            c_op_regimm, c_op_beq, c_op_bne, c_op_blez, c_op_bgtz: begin
                if (bht_q[w_rd_idx][1]) w_pred_pc = w_br_t;
            end
            c_op_j: w_pred_pc = w_j_t;
            c_op_jal: begin
                w_pred_pc = w_j_t;
                w_push    = 1'b1;
            end
            c_op_special: begin
                if (w_funct == c_fn_jr && w_rs == 5'd31 && ras_cnt_q != '0) begin
                    w_pred_pc = ras_q[ras_top_q - 1'b1];
                    w_pop     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.predTaken = !bus.redirectValid && (w_pred_pc != w_seq);
    assign bus.pc        = pc_q;

    always_comb begin
        if (bus.redirectValid)  pc_d = bus.redirectPC;
        else if (bus.stall)     pc_d = pc_q;
        else                    pc_d = w_pred_pc;
    end

    always_comb begin
        ras_top_d = ras_top_q;
        ras_cnt_d = ras_cnt_q;
        if (w_commit && w_push) begin
            ras_top_d = ras_top_q + 1'b1;
            // A full stack overwrites its oldest entry, so the count stays at full.
            if (ras_cnt_q != c_ras_full) ras_cnt_d = ras_cnt_q + 1'b1;
        end else if (w_commit && w_pop) begin
            ras_top_d = ras_top_q - 1'b1;
            ras_cnt_d = ras_cnt_q - 1'b1;
        end
    end

    always_comb begin
        w_upd_cnt = bht_q[w_upd_idx];
        if (bus.updateTaken && bht_q[w_upd_idx] != 2'b11)       w_upd_cnt = bht_q[w_upd_idx] + 2'b01;
        else if (!bus.updateTaken && bht_q[w_upd_idx] != 2'b00) w_upd_cnt = bht_q[w_upd_idx] - 2'b01;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            ras_top_q <= '0;
            ras_cnt_q <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
            for (int i = 0; i < RAS_DEPTH; i++)   ras_q[i] <= '0;
        end else begin
            pc_q      <= pc_d;
            ras_top_q <= ras_top_d;
            ras_cnt_q <= ras_cnt_d;
            // Training is independent of stall and redirect.
            if (bus.updateValid)     bht_q[w_upd_idx] <= w_upd_cnt;
            if (w_commit && w_push)  ras_q[ras_top_q] <= w_seq;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pc_predict.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_predict
// Description : Self-checking bench for pc_predict. Each driven cycle
//               pushes the expected next PC to a scoreboard queue. The
//               entry is popped and compared after the following rising
//               edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_predict;
    localparam logic [31:0] c_reset_pc = 32'h0000_0100;
    localparam logic [31:0] c_nop      = 32'h0000_0000;
    localparam logic [31:0] c_beq_m4   = 32'h1000_FFFC;  // beq $0,$0,-4
    localparam logic [31:0] c_jr31     = 32'h03E0_0008;
    localparam logic [31:0] c_jr5      = 32'h00A0_0008;

    logic clk;
    logic rst_n;
    pc_predict_if bus ();

    pc_predict #(
        .RESET_PC    (c_reset_pc),
        .BHT_ENTRIES (64),
        .RAS_DEPTH   (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_compared;
    int          n_mismatched;
    logic [31:0] sb_q [$];
    logic [31:0] exp_pc;

    function automatic logic [31:0] jal(input logic [31:0] target);
        return {6'h03, target[27:2]};
    endfunction

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Called at posedge+1 with the inputs already driven. This checks the
    // current pc and predTaken, then the pc after the next rising edge.
    task automatic cyc(input string tag, input logic exp_pred,
                       input logic [31:0] exp_next, input bit chk_pred = 1'b1);
        logic [31:0] popped;
        #2;
        check_value({tag, "_pc"}, bus.pc, exp_pc);
        if (chk_pred) check_value({tag, "_pred"}, {31'd0, bus.predTaken}, {31'd0, exp_pred});
        sb_q.push_back(exp_next);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_value({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            popped = sb_q.pop_front();
            check_value({tag, "_next"}, bus.pc, popped);
            exp_pc = popped;
        end
        bus.stall         = 1'b0;
        bus.redirectValid = 1'b0;
        bus.redirectPC    = '0;
        bus.updateValid   = 1'b0;
        bus.updatePC      = '0;
        bus.updateTaken   = 1'b0;
        bus.instruction   = c_nop;
    endtask

    task automatic train(input logic [31:0] upc, input logic taken);
        bus.updateValid = 1'b1;
        bus.updatePC    = upc;
        bus.updateTaken = taken;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirectValid = 1'b1;
        bus.redirectPC    = target;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_compared = 0; n_mismatched = 0;
        rst_n = 1'b0;
        bus.stall = 1'b0; bus.instruction = c_nop;
        bus.redirectValid = 1'b0; bus.redirectPC = '0;
        bus.updateValid = 1'b0; bus.updatePC = '0; bus.updateTaken = 1'b0;
        exp_pc = c_reset_pc;

        // Reset holds the pc through edges. predTaken follows the instruction.
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_pc", bus.pc, c_reset_pc);
        bus.instruction = jal(32'h0000_0400);
        #1;
        check_value("rst_pred_jal", {31'd0, bus.predTaken}, 32'd1);
        @(posedge clk);
        #1;
        check_value("rst_hold_pc", bus.pc, c_reset_pc);
        bus.instruction = c_nop;
        rst_n = 1'b1;

        // 1. Sequential fetch
        cyc("seq0", 1'b0, 32'h104);
        cyc("seq1", 1'b0, 32'h108);

        // 2. BHT learning on beq at 0x200
        redirect(32'h200);                                       cyc("redir200", 1'b0, 32'h200);
        bus.instruction = c_beq_m4;                              cyc("beq_nt", 1'b0, 32'h204);
        train(32'h200, 1'b1);                                    cyc("trn1", 1'b0, 32'h208);
        train(32'h200, 1'b1); redirect(32'h200);                 cyc("trn2", 1'b0, 32'h200);
        bus.instruction = c_beq_m4;                              cyc("beq_t", 1'b1, 32'h1F4);
        train(32'h200, 1'b1);                                    cyc("sat1", 1'b0, 32'h1F8);
        train(32'h200, 1'b1);                                    cyc("sat2", 1'b0, 32'h1FC);
        train(32'h200, 1'b1);                                    cyc("sat3", 1'b0, 32'h200);
        // Same-cycle read and train return the old counter value.
        bus.instruction = c_beq_m4; train(32'h200, 1'b0);        cyc("beq_c3", 1'b1, 32'h1F4);
        cyc("w0", 1'b0, 32'h1F8); cyc("w1", 1'b0, 32'h1FC); cyc("w2", 1'b0, 32'h200);
        bus.instruction = c_beq_m4; train(32'h200, 1'b0);        cyc("beq_c2", 1'b1, 32'h1F4);
        cyc("w3", 1'b0, 32'h1F8); cyc("w4", 1'b0, 32'h1FC); cyc("w5", 1'b0, 32'h200);
        bus.instruction = c_beq_m4;                              cyc("beq_c1", 1'b0, 32'h204);

        // 3. Jump and return
        redirect(32'h300);                                       cyc("redir300", 1'b0, 32'h300);
        bus.instruction = 32'h0C00_0040;                         cyc("jal300", 1'b1, 32'h100);
        bus.instruction = c_jr31;                                cyc("jr31", 1'b1, 32'h304);
        bus.instruction = c_jr5;                                 cyc("jr5", 1'b0, 32'h308);
        bus.instruction = c_jr31;                                cyc("jr31_empty", 1'b0, 32'h30C);

        // 4. RAS overflow
        redirect(32'h10);                                        cyc("redir10", 1'b0, 32'h10);
        bus.instruction = jal(32'h20);                           cyc("jal10", 1'b1, 32'h20);
        bus.instruction = jal(32'h30);                           cyc("jal20", 1'b1, 32'h30);
        bus.instruction = jal(32'h40);                           cyc("jal30", 1'b1, 32'h40);
        bus.instruction = jal(32'h50);                           cyc("jal40", 1'b1, 32'h50);
        bus.instruction = jal(32'h600);                          cyc("jal50", 1'b1, 32'h600);
        bus.instruction = c_jr31;                                cyc("pop1", 1'b1, 32'h54);
        bus.instruction = c_jr31;                                cyc("pop2", 1'b1, 32'h44);
        bus.instruction = c_jr31;                                cyc("pop3", 1'b1, 32'h34);
        bus.instruction = c_jr31;                                cyc("pop4", 1'b1, 32'h24);
        bus.instruction = c_jr31;                                cyc("pop5", 1'b0, 32'h28);

        // 5. Stall vs redirect
        bus.instruction = jal(32'h400); bus.stall = 1'b1;        cyc("stall", 1'b1, 32'h28, 1'b0);
        bus.instruction = jal(32'h400); bus.stall = 1'b1;
        redirect(32'h800);                                       cyc("stall_redir", 1'b0, 32'h800);
        bus.instruction = c_jr31;                                cyc("no_push", 1'b0, 32'h804);

        // 6. Asynchronous reset after a taken branch
        train(32'h200, 1'b1); redirect(32'h200);                 cyc("pre_rst", 1'b0, 32'h200);
        bus.instruction = c_beq_m4;                              cyc("beq_t2", 1'b1, 32'h1F4);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async_rst_pc", bus.pc, c_reset_pc);
        @(posedge clk);
        #1;
        check_value("async_hold_pc", bus.pc, c_reset_pc);
        rst_n = 1'b1;
        exp_pc = c_reset_pc;
        redirect(32'h200);                                       cyc("post_rst", 1'b0, 32'h200);
        bus.instruction = c_beq_m4;                              cyc("beq_reset", 1'b0, 32'h204);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
`default_nettype wire
